// File: rtl/mcpu_mux_pkg.sv
// rtl/mcpu_mux_pkg.sv - arbitration modes, default sizes and output-stage state type
package mcpu_mux_pkg;

   localparam int MUX_MODE_RR   = 0;
   localparam int MUX_MODE_PRIO = 1;

   localparam int MUX_DEF_WIDTH = 32;
   localparam int MUX_DEF_N     = 4;

   // The output stage is either empty or holding one word; the encoding doubles as out_valid.
   typedef enum logic {
      MUX_EMPTY = 1'b0,
      MUX_FULL  = 1'b1
   } mux_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational one-hot arbiter, round-robin from ptr or fixed lowest-index priority
module rr_arbiter
   import mcpu_mux_pkg::*;
#(
   parameter int N = MUX_DEF_N,
   parameter int MODE = MUX_MODE_RR,
   localparam int SEL_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [SEL_W-1:0] grant_idx,
   output logic             any_grant
);

   always_comb begin
      int idx;
      logic [SEL_W-1:0] idx_s;
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      idx       = 0;
      idx_s     = '0;
      // Visit candidates in priority order; the first requester seen wins.
      for (int k = 0; k < N; k++) begin
         idx   = (MODE == MUX_MODE_PRIO) ? k : (int'(ptr) + k) % N;
         idx_s = SEL_W'(idx);
         if (!any_grant && req[idx_s]) begin
            any_grant    = 1'b1;
            grant[idx_s] = 1'b1;
            grant_idx    = idx_s;
         end
      end
   end

endmodule

// File: rtl/mux_arb_reg.sv
// rtl/mux_arb_reg.sv - N-input arbitrating selector with one registered valid/ready output stage
module mux_arb_reg
   import mcpu_mux_pkg::*;
#(
   parameter int WIDTH = MUX_DEF_WIDTH,
   parameter int N = MUX_DEF_N,
   parameter int MODE = MUX_MODE_RR,
   localparam int SEL_W = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [SEL_W-1:0]   out_src,
   output logic               out_valid,
   input  logic               out_ready
);

   mux_state_e       state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [SEL_W-1:0] src_q, src_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;

   logic [N-1:0]     grant;
   logic [SEL_W-1:0] grant_idx;
   logic             any_grant;
   logic             load_en;
   logic [WIDTH-1:0] chan_data [N];

   for (genvar i = 0; i < N; i++) begin : g_chan
      assign chan_data[i] = in_data[i*WIDTH +: WIDTH];
   end

   rr_arbiter #(
      .N    (N),
      .MODE (MODE)
   ) u_arb (
      .req       (in_valid),
      .ptr       (ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_grant (any_grant)
   );

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      src_d   = src_q;
      ptr_d   = ptr_q;
      // rst gates load_en so no source sees an accept while the stage is being cleared.
      load_en  = !rst && ((state_q == MUX_EMPTY) || out_ready);
      in_ready = load_en ? grant : '0;
      if (load_en) begin
         if (any_grant) begin
            state_d = MUX_FULL;
            data_d  = chan_data[grant_idx];
            src_d   = grant_idx;
            ptr_d   = (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + SEL_W'(1);
         end else begin
            state_d = MUX_EMPTY;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= MUX_EMPTY;
         data_q  <= '0;
         src_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         src_q   <= src_d;
         ptr_q   <= ptr_d;
      end
   end

   assign out_valid = (state_q == MUX_FULL);
   assign out_data  = data_q;
   assign out_src   = src_q;

endmodule

// File: tb/tb_mux_arb_reg.sv
// tb/tb_mux_arb_reg.sv - directed and soak bench for mux_arb_reg
module tb_mux_arb_reg;

   logic clk;
   logic rst;

   logic [127:0] rr_in_data;
   logic [3:0]   rr_in_valid, rr_in_ready;
   logic [31:0]  rr_out_data;
   logic [1:0]   rr_out_src;
   logic         rr_out_valid, rr_out_ready;

   logic [127:0] pr_in_data;
   logic [3:0]   pr_in_valid, pr_in_ready;
   logic [31:0]  pr_out_data;
   logic [1:0]   pr_out_src;
   logic         pr_out_valid, pr_out_ready;

   logic [23:0]  sk_in_data;
   logic [2:0]   sk_in_valid, sk_in_ready;
   logic [7:0]   sk_out_data;
   logic [1:0]   sk_out_src;
   logic         sk_out_valid, sk_out_ready;

   int checks;
   int failures;

   mux_arb_reg #(.WIDTH(32), .N(4), .MODE(0)) u_rr (
      .clk(clk), .rst(rst), .in_data(rr_in_data), .in_valid(rr_in_valid), .in_ready(rr_in_ready),
      .out_data(rr_out_data), .out_src(rr_out_src), .out_valid(rr_out_valid), .out_ready(rr_out_ready)
   );

   mux_arb_reg #(.WIDTH(32), .N(4), .MODE(1)) u_pr (
      .clk(clk), .rst(rst), .in_data(pr_in_data), .in_valid(pr_in_valid), .in_ready(pr_in_ready),
      .out_data(pr_out_data), .out_src(pr_out_src), .out_valid(pr_out_valid), .out_ready(pr_out_ready)
   );

   mux_arb_reg #(.WIDTH(8), .N(3), .MODE(0)) u_sk (
      .clk(clk), .rst(rst), .in_data(sk_in_data), .in_valid(sk_in_valid), .in_ready(sk_in_ready),
      .out_data(sk_out_data), .out_src(sk_out_src), .out_valid(sk_out_valid), .out_ready(sk_out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rr_in_valid = 4'hF;
      rr_out_ready = 1'b1;
      pr_in_valid = 4'hF;
      pr_out_ready = 1'b1;
      tick();
      tick();
      checks++;
      if (rr_out_valid !== 1'b0 || rr_out_data !== 32'h0 || rr_out_src !== 2'd0) begin
         failures++;
         $display("FAIL reset_out valid=%b data=%h src=%0d need 0/0/0", rr_out_valid, rr_out_data, rr_out_src);
      end
      checks++;
      if (rr_in_ready !== 4'h0 || pr_in_ready !== 4'h0) begin
         failures++;
         $display("FAIL reset_in_ready rr=%b pr=%b need 0000", rr_in_ready, pr_in_ready);
      end
      rr_in_valid = 4'h0;
      pr_in_valid = 4'h0;
      rst = 1'b0;
      #1;
      checks++;
      if (rr_in_ready !== 4'h0 || rr_out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle in_ready=%b valid=%b need 0000/0", rr_in_ready, rr_out_valid);
      end
   endtask

   task automatic test_single();
      rr_in_data[64 +: 32] = 32'hDEADBEEF;
      rr_in_valid = 4'b0100;
      rr_out_ready = 1'b1;
      #1;
      checks++;
      if (rr_in_ready !== 4'b0100) begin
         failures++;
         $display("FAIL single_in_ready got=%b need 0100", rr_in_ready);
      end
      tick();
      rr_in_valid = 4'b0000;
      checks++;
      if (rr_out_valid !== 1'b1 || rr_out_data !== 32'hDEADBEEF || rr_out_src !== 2'd2) begin
         failures++;
         $display("FAIL single_out valid=%b data=%h src=%0d need 1/deadbeef/2", rr_out_valid, rr_out_data, rr_out_src);
      end
      tick();
      checks++;
      if (rr_out_valid !== 1'b0 || rr_out_data !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL single_drain valid=%b data=%h need 0/deadbeef", rr_out_valid, rr_out_data);
      end
   endtask

   task automatic test_rr_wrap();
      logic [3:0] exp_rdy;
      logic [1:0] exp_src;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) rr_in_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
      rr_in_valid = 4'hF;
      rr_out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         exp_src = 2'(k % 4);
         exp_rdy = 4'b0001 << exp_src;
         #1;
         checks++;
         if (rr_in_ready !== exp_rdy) begin
            failures++;
            $display("FAIL rr_in_ready step=%0d got=%b need %b", k, rr_in_ready, exp_rdy);
         end
         tick();
         checks++;
         if (rr_out_valid !== 1'b1 || rr_out_src !== exp_src || rr_out_data !== 32'hA000_0000 + 32'(exp_src)) begin
            failures++;
            $display("FAIL rr_out step=%0d valid=%b src=%0d data=%h need src %0d", k, rr_out_valid, rr_out_src, rr_out_data, exp_src);
         end
      end
      rr_in_valid = 4'h0;
   endtask

   task automatic test_backpressure();
      rr_in_data[0 +: 32] = 32'h12345678;
      rr_in_valid = 4'b0001;
      rr_out_ready = 1'b1;
      #1;
      checks++;
      if (rr_in_ready !== 4'b0001) begin
         failures++;
         $display("FAIL bp_load_ready got=%b need 0001", rr_in_ready);
      end
      tick();
      rr_in_data[0 +: 32] = 32'hCAFEF00D;
      rr_out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++;
         if (rr_in_ready !== 4'b0000) begin
            failures++;
            $display("FAIL bp_in_ready cyc=%0d got=%b need 0000", k, rr_in_ready);
         end
         tick();
         checks++;
         if (rr_out_valid !== 1'b1 || rr_out_data !== 32'h12345678 || rr_out_src !== 2'd0) begin
            failures++;
            $display("FAIL bp_hold cyc=%0d valid=%b data=%h src=%0d need 1/12345678/0", k, rr_out_valid, rr_out_data, rr_out_src);
         end
      end
      rr_out_ready = 1'b1;
      #1;
      checks++;
      if (rr_in_ready !== 4'b0001) begin
         failures++;
         $display("FAIL bp_release_ready got=%b need 0001", rr_in_ready);
      end
      tick();
      rr_in_valid = 4'h0;
      checks++;
      if (rr_out_valid !== 1'b1 || rr_out_data !== 32'hCAFEF00D || rr_out_src !== 2'd0) begin
         failures++;
         $display("FAIL bp_next valid=%b data=%h src=%0d need 1/cafef00d/0", rr_out_valid, rr_out_data, rr_out_src);
      end
   endtask

   task automatic test_reset_mid();
      rr_in_data[32 +: 32] = 32'h0BADC0DE;
      rr_in_valid = 4'b0010;
      rr_out_ready = 1'b1;
      tick();
      rr_in_valid = 4'b0000;
      rr_out_ready = 1'b0;
      checks++;
      if (rr_out_valid !== 1'b1 || rr_out_src !== 2'd1) begin
         failures++;
         $display("FAIL mid_setup valid=%b src=%0d need 1/1", rr_out_valid, rr_out_src);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (rr_out_valid !== 1'b0 || rr_out_data !== 32'h0 || rr_out_src !== 2'd0) begin
         failures++;
         $display("FAIL mid_async valid=%b data=%h src=%0d need 0/0/0", rr_out_valid, rr_out_data, rr_out_src);
      end
      for (int i = 0; i < 4; i++) rr_in_data[i*32 +: 32] = 32'hB000_0000 + 32'(i);
      rr_in_valid = 4'hF;
      rr_out_ready = 1'b1;
      #1;
      checks++;
      if (rr_in_ready !== 4'h0) begin
         failures++;
         $display("FAIL mid_rst_ready got=%b need 0000", rr_in_ready);
      end
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (rr_in_ready !== 4'b0001) begin
         failures++;
         $display("FAIL mid_first_grant got=%b need 0001", rr_in_ready);
      end
      tick();
      rr_in_valid = 4'h0;
      checks++;
      if (rr_out_valid !== 1'b1 || rr_out_src !== 2'd0 || rr_out_data !== 32'hB000_0000) begin
         failures++;
         $display("FAIL mid_first_out valid=%b src=%0d data=%h need 1/0/b0000000", rr_out_valid, rr_out_src, rr_out_data);
      end
   endtask

   task automatic test_priority();
      pr_in_data[32 +: 32] = 32'h11111111;
      pr_in_data[96 +: 32] = 32'h33333333;
      pr_in_valid = 4'b1010;
      pr_out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++;
         if (pr_in_ready !== 4'b0010) begin
            failures++;
            $display("FAIL prio_ready step=%0d got=%b need 0010", k, pr_in_ready);
         end
         tick();
         checks++;
         if (pr_out_valid !== 1'b1 || pr_out_src !== 2'd1 || pr_out_data !== 32'h11111111) begin
            failures++;
            $display("FAIL prio_out step=%0d valid=%b src=%0d data=%h need 1/1/11111111", k, pr_out_valid, pr_out_src, pr_out_data);
         end
      end
      pr_in_valid = 4'b1000;
      #1;
      checks++;
      if (pr_in_ready !== 4'b1000) begin
         failures++;
         $display("FAIL prio_drop_ready got=%b need 1000", pr_in_ready);
      end
      tick();
      pr_in_valid = 4'b0000;
      checks++;
      if (pr_out_valid !== 1'b1 || pr_out_src !== 2'd3 || pr_out_data !== 32'h33333333) begin
         failures++;
         $display("FAIL prio_drop_out valid=%b src=%0d data=%h need 1/3/33333333", pr_out_valid, pr_out_src, pr_out_data);
      end
   endtask

   task automatic test_soak();
      logic [5:0] nxt_src [3];
      logic [5:0] nxt_out [3];
      int         wait_cnt [3];
      int         acc_total;
      int         out_total;
      logic [2:0] acc;
      logic [7:0] exp_word;
      for (int c = 0; c < 3; c++) begin
         nxt_src[c] = '0;
         nxt_out[c] = '0;
         wait_cnt[c] = 0;
      end
      acc_total = 0;
      out_total = 0;
      acc = '0;
      sk_in_valid = '0;
      sk_out_ready = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int c = 0; c < 3; c++) begin
            if (acc[c]) nxt_src[c] = nxt_src[c] + 6'd1;
            if (!sk_in_valid[c] || acc[c]) sk_in_valid[c] = ($urandom_range(0, 2) != 0);
            sk_in_data[c*8 +: 8] = {c[1:0], nxt_src[c]};
         end
         sk_out_ready = ($urandom_range(0, 3) != 0);
         #1;
         checks++;
         if ($countones(sk_in_ready) > 1 || (sk_in_ready & ~sk_in_valid) != 3'b000) begin
            failures++;
            $display("FAIL soak_onehot cyc=%0d in_ready=%b in_valid=%b", cyc, sk_in_ready, sk_in_valid);
         end
         checks++;
         if (sk_out_valid && !sk_out_ready && sk_in_ready != 3'b000) begin
            failures++;
            $display("FAIL soak_backpressure cyc=%0d in_ready=%b need 000", cyc, sk_in_ready);
         end
         checks++;
         if ((!sk_out_valid || sk_out_ready) && sk_in_valid != 3'b000 && sk_in_ready == 3'b000) begin
            failures++;
            $display("FAIL soak_idle cyc=%0d in_valid=%b in_ready=000", cyc, sk_in_valid);
         end
         if (sk_out_valid && sk_out_ready) begin
            checks++;
            if (sk_out_src > 2'd2) begin
               failures++;
               $display("FAIL soak_src cyc=%0d got=%0d need <3", cyc, sk_out_src);
            end else begin
               exp_word = {sk_out_src, nxt_out[sk_out_src]};
               if (sk_out_data !== exp_word) begin
                  failures++;
                  $display("FAIL soak_order cyc=%0d got=%h need %h", cyc, sk_out_data, exp_word);
               end
               nxt_out[sk_out_src] = nxt_out[sk_out_src] + 6'd1;
            end
            out_total++;
         end
         acc = sk_in_valid & sk_in_ready;
         acc_total += $countones(acc);
         if (acc != 3'b000) begin
            for (int c = 0; c < 3; c++) begin
               if (acc[c]) wait_cnt[c] = 0;
               else if (sk_in_valid[c]) wait_cnt[c]++;
               checks++;
               if (wait_cnt[c] > 2) begin
                  failures++;
                  $display("FAIL soak_fair cyc=%0d chan=%0d waited=%0d need <=2", cyc, c, wait_cnt[c]);
               end
            end
         end
         tick();
      end
      checks++;
      if (acc_total != out_total + (sk_out_valid ? 1 : 0)) begin
         failures++;
         $display("FAIL soak_count accepted=%0d delivered=%0d held=%b", acc_total, out_total, sk_out_valid);
      end
      sk_in_valid = '0;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rr_in_data = '0;
      pr_in_data = '0;
      sk_in_data = '0;
      rr_in_valid = '0;
      pr_in_valid = '0;
      sk_in_valid = '0;
      rr_out_ready = 1'b0;
      pr_out_ready = 1'b0;
      sk_out_ready = 1'b0;
      test_reset();
      test_single();
      test_rr_wrap();
      test_backpressure();
      test_reset_mid();
      test_priority();
      test_soak();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
